// File: rtl/ram_bist_pkg.sv
// Shared types and pattern helper for the RAM BIST controller.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    CK0  = 3'd3,
    WR1  = 3'd4,
    RD1  = 3'd5,
    CK1  = 3'd6,
    DONE = 3'd7
  } bist_state_t;

  // Callers truncate to their data width; low bits of sum and inversion are width-independent.
  function automatic logic [31:0] exp_data(input logic [31:0] seed, input logic [31:0] addr,
                                           input logic inv);
    logic [31:0] v;
    v = seed + addr;
    return inv ? ~v : v;
  endfunction

endpackage

// File: rtl/ram_bist_ctrl.sv
// March-style BIST for a small single-port RAM: write/read/check with a seeded
// address pattern, then again with the inverted pattern, reporting the first failure.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    mem_sel,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ADDR_WIDTH+1:0]   err_count,
  output logic [ADDR_WIDTH-1:0]   fail_addr,
  output logic                    fail_pass
);

  localparam int EW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 1);

  bist_state_t           state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] seed_q, seed_n;
  logic                  go;

  // One-cycle-delayed read tag: the RAM returns data the edge after the read.
  logic                  chk_vld;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic                  chk_inv;
  logic [DATA_WIDTH-1:0] chk_exp;
  logic                  mism;
  logic [EW-1:0]         err_n;

  logic                  wr_n, rd_n, ck_n, inv_n;
  logic                  sel_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] din_n;

  assign go = (state == IDLE) && start;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (start) begin
        state_n = WR0;
        cnt_n   = '0;
      end
      WR0, RD0, WR1, RD1: begin
        cnt_n = cnt + ADDR_WIDTH'(1);
        if (cnt == LAST) begin
          case (state)
            WR0:     state_n = RD0;
            RD0:     state_n = CK0;
            WR1:     state_n = RD1;
            default: state_n = CK1;
          endcase
        end
      end
      CK0: begin
        state_n = WR1;
        cnt_n   = '0;
      end
      CK1:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state register.
  always_comb begin
    wr_n   = (state_n == WR0) || (state_n == WR1);
    rd_n   = (state_n == RD0) || (state_n == RD1);
    ck_n   = (state_n == CK0) || (state_n == CK1);
    inv_n  = (state_n == WR1) || (state_n == RD1) || (state_n == CK1);
    seed_n = go ? seed : seed_q;
    sel_n  = wr_n;
    addr_n = (wr_n || rd_n) ? cnt_n : (ck_n ? LAST : '0);
    din_n  = wr_n ? DATA_WIDTH'(exp_data(32'(seed_n), 32'(cnt_n), inv_n)) : '0;
  end

  always_comb begin
    chk_exp = DATA_WIDTH'(exp_data(32'(seed_q), 32'(chk_addr), chk_inv));
    mism    = chk_vld && (mem_dout != chk_exp);
    err_n   = err_count + EW'(mism);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      seed_q    <= '0;
      chk_vld   <= 1'b0;
      chk_addr  <= '0;
      chk_inv   <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_pass <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      seed_q   <= seed_n;
      chk_vld  <= (state == RD0) || (state == RD1);
      chk_addr <= cnt;
      chk_inv  <= (state == RD1);
      mem_sel  <= sel_n;
      mem_addr <= addr_n;
      mem_din  <= din_n;
      busy     <= (state_n != IDLE) && (state_n != DONE);
      done     <= (state_n == DONE);
      if (go) begin
        err_count <= '0;
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_pass <= 1'b0;
      end else begin
        if (mism) begin
          err_count <= err_n;
          if (err_count == '0) begin
            fail_addr <= chk_addr;
            fail_pass <= chk_inv;
          end
        end
        // err_n folds in a mismatch from the final CK1 compare on this same edge.
        if (state_n == DONE) pass <= (err_n == '0);
      end
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench: stimulus queues expected writes/results, a negedge monitor checks them.
module tb_ram_bist_ctrl;
  localparam int AW = 2;
  localparam int DW = 4;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] seed = '0;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic          busy, done, pass;
  logic [AW+1:0] err_count;
  logic [AW-1:0] fail_addr;
  logic          fail_pass;

  ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_pass(fail_pass)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int cyc; logic ok; logic [3:0] err; logic [1:0] fa; logic fp; } res_t;
  typedef struct { logic [1:0] a; logic [3:0] d; } wr_t;
  res_t res_q[$];
  wr_t  wr_q[$];

  // RAM model with read-side fault injection: xor mask per pattern pass/address, and-mask for stuck-at-0.
  logic [3:0] xm[2][4];
  logic [3:0] am = 4'hF;
  logic [3:0] mem[4] = '{default: 4'h0};
  int wr_cnt = 0;

  always @(posedge clk) begin
    int rp;
    rp = ((wr_cnt - 1) / N) % 2;
    if (reset) wr_cnt <= 0;
    else if (mem_sel) begin
      mem[mem_addr] <= mem_din;
      wr_cnt <= wr_cnt + 1;
    end else mem_dout <= (mem[mem_addr] ^ xm[rp][mem_addr]) & am;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic res_t model(logic [3:0] s, int c);
    res_t r;
    logic [3:0] e, got;
    r.cyc = c; r.err = 0; r.fa = 0; r.fp = 0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < N; a++) begin
        e = 4'(s + a);
        if (p == 1) e = ~e;
        got = (e ^ xm[p][a]) & am;
        if (got != e) begin
          if (r.err == 0) begin r.fa = 2'(a); r.fp = 1'(p); end
          r.err++;
        end
      end
    r.ok = (r.err == 0);
    return r;
  endfunction

  task automatic push_run(logic [3:0] s, int c);
    wr_t w;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < N; a++) begin
        w.a = 2'(a);
        w.d = (p == 1) ? ~4'(s + a) : 4'(s + a);
        wr_q.push_back(w);
      end
    res_q.push_back(model(s, c + 18));
  endtask

  // Called at posedge+1; returns one cycle later with cyc equal to the start edge.
  task automatic kick(input logic [3:0] s, output int S);
    seed = s;
    start = 1'b1;
    S = cyc + 1;
    push_run(s, S);
    @(posedge clk); #1;
    start = 1'b0;
    seed = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((res_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(res_q.size() + wr_q.size()), 32'd0);
    res_q.delete();
    wr_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic clear_faults();
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < N; a++) xm[p][a] = 4'h0;
    am = 4'hF;
  endtask

  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    if (!reset) begin
      if (mem_sel) begin
        if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          w = wr_q.pop_front();
          chk("write", 32'({busy, mem_addr, mem_din}), 32'({1'b1, w.a, w.d}));
        end
      end else if (!busy) begin
        chk("idle_mem_bus", 32'({mem_addr, mem_din}), 32'd0);
      end
      if (done) begin
        if (res_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          r = res_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(r.cyc));
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("pass", 32'(pass), 32'(r.ok));
          chk("err_count", 32'(err_count), 32'(r.err));
          chk("fail_addr", 32'(fail_addr), 32'(r.fa));
          chk("fail_pass", 32'(fail_pass), 32'(r.fp));
        end
      end
    end
  end

  initial begin
    int S;
    clear_faults();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({busy, done, pass, err_count, fail_addr, fail_pass}), 32'd0);
    chk("reset_mem_bus", 32'({mem_sel, mem_addr, mem_din}), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // fault-free, seed 3
    kick(4'h3, S);
    drain();

    // dout bit 0 stuck at 0, seed 0
    am = 4'hE;
    kick(4'h0, S);
    drain();

    // address 2 corrupted on read in the inverted pass only
    clear_faults();
    xm[1][2] = 4'h5;
    kick(4'h7, S);
    drain();

    // start pulse during RD0 is ignored
    clear_faults();
    am = 4'hE;
    kick(4'h9, S);
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b1;
    seed = 4'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // reset during WR1 aborts the run and clears status
    am = 4'hE;
    kick(4'h0, S);
    repeat (10) begin @(posedge clk); #1; end
    chk("err_before_reset", 32'(err_count), 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrun_reset_status", 32'({busy, done, pass, err_count}), 32'd0);
    chk("midrun_reset_bus", 32'({mem_sel, mem_addr, mem_din}), 32'd0);
    reset = 1'b0;
    res_q.delete();
    wr_q.delete();
    @(posedge clk); #1;
    clear_faults();
    kick(4'($urandom), S);
    drain();

    // start held for 40 cycles: two back-to-back runs
    seed = 4'hA;
    start = 1'b1;
    S = cyc + 1;
    push_run(4'hA, S);
    push_run(4'hA, S + 20);
    repeat (40) @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    // randomized faults and seeds
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 2; p++)
        for (int a = 0; a < N; a++)
          xm[p][a] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      am = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      kick(4'($urandom), S);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, want < 10000", cyc);
    $fatal(1);
  end

endmodule
